// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and byte-lane helpers for the memory port arbiter.
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} arb_state_t;
  typedef enum logic {PORT_I, PORT_D} port_t;
  typedef logic [0:3][7:0] lanes_t;
  function automatic logic [31:0] pack_lanes(lanes_t l);
    return {l[0], l[1], l[2], l[3]};
  endfunction
  function automatic lanes_t unpack_lanes(logic [31:0] w);
    lanes_t l;
    l[0] = w[31:24];
    l[1] = w[23:16];
    l[2] = w[15:8];
    l[3] = w[7:0];
    return l;
  endfunction
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: requester and memory-side signals of the shared memory port.
interface mem_port_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_rdata;
  logic              i_done;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_done;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  lanes_t            mem_data_in;
  lanes_t            mem_data_out;
  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_data_out,
    output i_rdata, i_done, d_rdata, d_done, mem_addr, mem_we, mem_data_in
  );
  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_data_out,
    input  i_rdata, i_done, d_rdata, d_done, mem_addr, mem_we, mem_data_in
  );
endinterface

// File: rtl/mem_lat_counter.sv
// mem_lat_counter: loadable down-counter timing one fixed-latency memory access.
module mem_lat_counter #(
  parameter int MEM_LATENCY = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic dec,
  output logic zero
);
  localparam int W = $clog2(MEM_LATENCY + 1);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt <= '0;
    else if (load) cnt <= W'(MEM_LATENCY - 1);
    else if (dec && cnt != '0) cnt <= cnt - 1'b1;
  assign zero = cnt == '0;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sharing of one fixed-latency memory port between
// the instruction-fetch and data-cache miss paths.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LATENCY = 4,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32
) (
  input logic          clk,
  input logic          reset,
  mem_port_arbiter_if.slave bus
);
  arb_state_t        state, nxt;
  port_t             owner, win;
  logic              grant, zero, we, busy;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata, i_rd, d_rd;

  mem_lat_counter #(.MEM_LATENCY(MEM_LATENCY)) u_cnt (
    .clk  (clk),
    .reset(reset),
    .load (grant),
    .dec  (busy),
    .zero (zero)
  );

  // owner doubles as the last-grant pointer: on a tie the other port wins
  always_comb begin
    busy = state == BUSY;
    grant = state == IDLE && (bus.i_req || bus.d_req);
    win = (bus.i_req && bus.d_req) ? (owner == PORT_I ? PORT_D : PORT_I)
                                   : (bus.d_req ? PORT_D : PORT_I);
    nxt = state == IDLE ? (grant ? BUSY : IDLE) : state == BUSY ? (zero ? DONE : BUSY) : IDLE;
    bus.mem_addr = busy ? addr : '0;
    bus.mem_we = busy && we;
    bus.mem_data_in = (busy && we) ? unpack_lanes(wdata) : '0;
    bus.i_done = state == DONE && owner == PORT_I;
    bus.d_done = state == DONE && owner == PORT_D;
    bus.i_rdata = i_rd;
    bus.d_rdata = d_rd;
  end

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      owner <= PORT_I;
      addr  <= '0;
      we    <= 1'b0;
      wdata <= '0;
      i_rd  <= '0;
      d_rd  <= '0;
    end else begin
      state <= nxt;
      if (grant) begin
        owner <= win;
        addr  <= (win == PORT_D ? bus.d_addr : bus.i_addr) & ~ADDR_W'(3);
        we    <= win == PORT_D && bus.d_we;
        wdata <= bus.d_wdata;
      end
      if (busy && zero && !we) begin
        if (owner == PORT_I) i_rd <= pack_lanes(bus.mem_data_out);
        else d_rd <= pack_lanes(bus.mem_data_out);
      end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: cycle table for the main paths plus directed multi-cycle corner cases.
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int errors = 0;
  string ctx;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();

  mem_port_arbiter #(.MEM_LATENCY(4), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  mem_port_arbiter #(.MEM_LATENCY(1), .ADDR_W(32), .DATA_W(32)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1)
  );

  typedef struct {
    logic        rst, ir;
    logic [31:0] ia;
    logic        dr, dw;
    logic [31:0] da, dwd, mo;
    logic        idn, ddn, mwe;
    logic [31:0] maddr, mdin, ird, drd;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(logic rst, logic ir, logic [31:0] ia, logic dr, logic dw,
                              logic [31:0] da, logic [31:0] dwd, logic [31:0] mo,
                              logic idn, logic ddn, logic mwe, logic [31:0] maddr,
                              logic [31:0] mdin, logic [31:0] ird, logic [31:0] drd);
    vec_t r;
    r = '{rst, ir, ia, dr, dw, da, dwd, mo, idn, ddn, mwe, maddr, mdin, ird, drd};
    tbl.push_back(r);
  endfunction

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s [%s]: got %h expected %h", n, ctx, act, exp);
    end
  endtask

  task automatic wait_done(input bit side_d, output int n);
    n = 0;
    while (!(side_d ? bus.d_done : bus.i_done) && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  initial begin
    int n;
    int seen;
    reset = 1'b0;
    {bus.i_req, bus.d_req, bus.d_we} = '0;
    {bus.i_addr, bus.d_addr, bus.d_wdata} = '0;
    bus.mem_data_out = '0;
    {bus1.i_req, bus1.d_req, bus1.d_we} = '0;
    {bus1.i_addr, bus1.d_addr, bus1.d_wdata} = '0;
    bus1.mem_data_out = '0;

    // reset, then instruction read of 0x1004
    add(0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0);
    for (int i = 0; i < 4; i++) add(1,1,32'h1004,0,0,0,0,32'hAABBCCDD, 0,0,0,32'h1004,0,0,0);
    add(1,1,32'h1004,0,0,0,0,32'hAABBCCDD, 1,0,0,0,0,32'hAABBCCDD,0);
    add(1,0,0,0,0,0,0,32'hAABBCCDD, 0,0,0,0,0,32'hAABBCCDD,0);
    // data write to unaligned 0x2003
    for (int i = 0; i < 4; i++)
      add(1,0,0,1,1,32'h2003,32'h11223344,32'h55667788, 0,0,1,32'h2000,32'h11223344,32'hAABBCCDD,0);
    add(1,0,0,1,1,32'h2003,32'h11223344,32'h55667788, 0,1,0,0,0,32'hAABBCCDD,0);
    add(1,0,0,0,0,0,0,0, 0,0,0,0,0,32'hAABBCCDD,0);
    // both requesting from reset: D, I, D, I
    add(0,1,32'h4001,1,0,32'h3002,0,32'hCAFEF00D, 0,0,0,0,0,0,0);
    for (int i = 0; i < 4; i++) add(1,1,32'h4001,1,0,32'h3002,0,32'hCAFEF00D, 0,0,0,32'h3000,0,0,0);
    add(1,1,32'h4001,1,0,32'h3002,0,32'hCAFEF00D, 0,1,0,0,0,0,32'hCAFEF00D);
    add(1,1,32'h4001,1,0,32'h3002,0,32'hCAFEF00D, 0,0,0,0,0,0,32'hCAFEF00D);
    for (int i = 0; i < 4; i++) add(1,1,32'h4001,1,0,32'h3002,0,32'h12345678, 0,0,0,32'h4000,0,0,32'hCAFEF00D);
    add(1,1,32'h4001,1,0,32'h3002,0,32'h12345678, 1,0,0,0,0,32'h12345678,32'hCAFEF00D);
    add(1,1,32'h4001,1,0,32'h3002,0,32'h12345678, 0,0,0,0,0,32'h12345678,32'hCAFEF00D);
    for (int i = 0; i < 4; i++) add(1,1,32'h4001,1,0,32'h3002,0,32'h12345678, 0,0,0,32'h3000,0,32'h12345678,32'hCAFEF00D);
    add(1,1,32'h4001,1,0,32'h3002,0,32'h12345678, 0,1,0,0,0,32'h12345678,32'h12345678);
    add(1,1,32'h4001,1,0,32'h3002,0,32'h12345678, 0,0,0,0,0,32'h12345678,32'h12345678);
    add(1,1,32'h4001,1,0,32'h3002,0,32'h12345678, 0,0,0,32'h4000,0,32'h12345678,32'h12345678);
    add(0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0);

    foreach (tbl[k]) begin
      ctx = $sformatf("row %0d", k);
      reset = tbl[k].rst;
      bus.i_req = tbl[k].ir;
      bus.i_addr = tbl[k].ia;
      bus.d_req = tbl[k].dr;
      bus.d_we = tbl[k].dw;
      bus.d_addr = tbl[k].da;
      bus.d_wdata = tbl[k].dwd;
      bus.mem_data_out = tbl[k].mo;
      @(posedge clk); #1;
      chk("i_done", 32'(bus.i_done), 32'(tbl[k].idn));
      chk("d_done", 32'(bus.d_done), 32'(tbl[k].ddn));
      chk("mem_we", 32'(bus.mem_we), 32'(tbl[k].mwe));
      chk("mem_addr", bus.mem_addr, tbl[k].maddr);
      chk("mem_data_in", bus.mem_data_in, tbl[k].mdin);
      chk("i_rdata", bus.i_rdata, tbl[k].ird);
      chk("d_rdata", bus.d_rdata, tbl[k].drd);
    end

    // reset in the second cycle of a write aborts it
    ctx = "reset mid-write";
    reset = 1'b1;
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h2000; bus.d_wdata = 32'hA5A5A5A5;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mem_we before reset", 32'(bus.mem_we), 32'd1);
    reset = 1'b0;
    #1;
    chk("mem_we async drop", 32'(bus.mem_we), 32'd0);
    chk("mem_addr async drop", bus.mem_addr, 32'd0);
    bus.d_req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (bus.d_done) seen++;
    end
    chk("no d_done after abort", 32'(seen), 32'd0);
    chk("d_rdata after abort", bus.d_rdata, 32'd0);
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h44; bus.mem_data_out = 32'hDEADBEEF;
    wait_done(1'b1, n);
    bus.d_req = 1'b0;
    chk("fresh read latency", 32'(n), 32'd5);
    chk("fresh read data", bus.d_rdata, 32'hDEADBEEF);
    @(posedge clk); #1;

    // instruction request dropped after one busy cycle still completes
    ctx = "drop i_req";
    bus.i_req = 1'b1; bus.i_addr = 32'h88; bus.mem_data_out = 32'h01020304;
    @(posedge clk); #1;
    chk("mem_addr busy", bus.mem_addr, 32'h88);
    @(posedge clk); #1;
    bus.i_req = 1'b0;
    wait_done(1'b0, n);
    chk("i_done after drop", 32'(n), 32'd3);
    chk("i_rdata after drop", bus.i_rdata, 32'h01020304);
    @(posedge clk); #1;
    chk("i_done one cycle", 32'(bus.i_done), 32'd0);

    // single-cycle-latency build
    ctx = "latency 1";
    bus1.d_req = 1'b1; bus1.d_we = 1'b0; bus1.d_addr = 32'h40; bus1.mem_data_out = 32'h0BADCAFE;
    @(posedge clk); #1;
    chk("L1 mem_addr", bus1.mem_addr, 32'h40);
    chk("L1 d_done early", 32'(bus1.d_done), 32'd0);
    bus1.d_req = 1'b0;
    @(posedge clk); #1;
    chk("L1 d_done", 32'(bus1.d_done), 32'd1);
    chk("L1 d_rdata", bus1.d_rdata, 32'h0BADCAFE);
    chk("L1 mem_addr done", bus1.mem_addr, 32'd0);
    @(posedge clk); #1;
    chk("L1 d_done pulse", 32'(bus1.d_done), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
